store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 91 +++++++++
 tb/tb_store_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the processor data port and a single-port data RAM.
// Stores queue in a circular FIFO and drain when the RAM port is idle; loads forward from pending stores.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [31:0]              dAddress,
  input  logic [31:0]              dWriteData,
  output logic [31:0]              dReadData,
  output logic                     stall,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [31:0]              ram_din,
  input  logic [31:0]              ram_dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] req_addr;
  logic              enq;
  logic              drain;
  logic [31:0]       fwd_data;
  logic              unused_addr_bits;

  assign req_addr         = dAddress[ADDR_W-1:0];
  assign unused_addr_bits = ^dAddress[31:ADDR_W];

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign stall = MemWrite & full;
  assign enq   = MemWrite & ~full;
  // Loads own the RAM port; the buffer drains only in cycles without a load.
  assign drain = ~empty & ~MemRead;

  assign ram_we   = drain;
  assign ram_addr = drain ? addr_q[head_q] : req_addr;
  assign ram_din  = drain ? data_q[head_q] : '0;

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwd_data = ram_dout;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (addr_q[head_q + PTR_W'(i)] == req_addr))
        fwd_data = data_q[head_q + PTR_W'(i)];
    end
  end

  assign dReadData = MemRead ? fwd_data : ram_dout;

  always_comb begin
    head_d  = drain ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; validity comes only from count_q and head_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= req_addr;
      data_q[tail_q] <= dWriteData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based model
// of the buffer and a reference memory image.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 9;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [31:0]       dAddress = '0;
  logic [31:0]       dWriteData = '0;
  logic [31:0]       dReadData;
  logic              stall;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;

  logic [31:0] tb_ram  [512];
  logic [31:0] ref_mem [512];

  typedef struct packed {
    logic [8:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData), .dReadData(dReadData),
    .stall(stall), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  assign ram_dout = tb_ram[ram_addr];
  always @(posedge clk) if (ram_we) tb_ram[ram_addr] <= ram_din;

  function automatic logic m_we();
    return (q.size() != 0) && !MemRead;
  endfunction

  function automatic logic [8:0] m_addr();
    return m_we() ? q[0].a : dAddress[8:0];
  endfunction

  function automatic logic m_stall();
    return MemWrite && (q.size() == DEPTH);
  endfunction

  function automatic logic [31:0] m_dread();
    logic [31:0] r;
    if (!MemRead) return ref_mem[m_addr()];
    r = ref_mem[dAddress[8:0]];
    foreach (q[i]) if (q[i].a == dAddress[8:0]) r = q[i].d;
    return r;
  endfunction

  // Inputs are applied just after a rising edge; outputs are sampled at the falling edge.
  task automatic drive(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = $urandom();
    MemRead    = rd;
    MemWrite   = wr;
    dAddress   = {r[31:9], a};
    dWriteData = d;
    #4;
  endtask

  task automatic tick();
    logic dr, en;
    ent_t e;
    @(posedge clk);
    dr = (q.size() != 0) && !MemRead;
    en = MemWrite && (q.size() < DEPTH);
    if (dr) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (en) begin
      e.a = dAddress[8:0];
      e.d = dWriteData;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MemWrite = 1'b1;
    #2;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", ram_we); else n_pass++;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_store();
    drive(1'b0, 1'b1, 9'h010, 32'h11);
    n_checks++; if (ram_we !== 1'b0) $display("FAIL single_we0: got %b want 0", ram_we); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (count !== 3'd1) $display("FAIL single_count1: got %0d want 1", count); else n_pass++;
    n_checks++; if (ram_we !== 1'b1) $display("FAIL single_we1: got %b want 1", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 9'h010) $display("FAIL single_addr: got %h want 010", ram_addr); else n_pass++;
    n_checks++; if (ram_din !== 32'h11) $display("FAIL single_din: got %h want 11", ram_din); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (count !== 3'd0) $display("FAIL single_count0: got %0d want 0", count); else n_pass++;
    n_checks++; if (tb_ram[9'h010] !== 32'h11) $display("FAIL single_ram: got %h want 11", tb_ram[9'h010]); else n_pass++;
  endtask

  task automatic test_full_stall();
    logic [8:0]  ea [3] = '{9'h028, 9'h02C, 9'h030};
    logic [31:0] ed [3] = '{32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 9'h020 + 9'(4 * i), 32'hA0 + 32'(i));
      n_checks++; if (stall !== 1'b0) $display("FAIL fill_stall%0d: got %b want 0", i, stall); else n_pass++;
      n_checks++; if (ram_we !== 1'b0) $display("FAIL fill_we%0d: got %b want 0", i, ram_we); else n_pass++;
      tick();
    end
    drive(1'b1, 1'b1, 9'h030, 32'hA4);
    n_checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else n_pass++;
    n_checks++; if (stall !== 1'b1) $display("FAIL full_stall: got %b want 1", stall); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL full_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 9'h030) $display("FAIL full_loadaddr: got %h want 030", ram_addr); else n_pass++;
    tick();
    drive(1'b0, 1'b1, 9'h030, 32'hA4);
    n_checks++; if (count !== 3'd4) $display("FAIL full_hold: got %0d want 4", count); else n_pass++;
    n_checks++; if (stall !== 1'b1) $display("FAIL full_drain_stall: got %b want 1", stall); else n_pass++;
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== 9'h020) $display("FAIL full_drain0: got we=%b addr=%h want we=1 addr=020", ram_we, ram_addr); else n_pass++;
    tick();
    drive(1'b0, 1'b1, 9'h030, 32'hA4);
    n_checks++; if (count !== 3'd3) $display("FAIL accept_count: got %0d want 3", count); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL accept_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (ram_addr !== 9'h024 || ram_din !== 32'hA1) $display("FAIL full_drain1: got addr=%h din=%h want 024/A1", ram_addr, ram_din); else n_pass++;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 9'h000, 32'h0);
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== ea[k] || ram_din !== ed[k])
        $display("FAIL full_drain%0d: got we=%b addr=%h din=%h want 1/%h/%h", k + 2, ram_we, ram_addr, ram_din, ea[k], ed[k]);
      else n_pass++;
      tick();
    end
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (empty !== 1'b1) $display("FAIL full_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_forwarding();
    tb_ram[9'h044]  = 32'hCAFE0044;
    ref_mem[9'h044] = 32'hCAFE0044;
    drive(1'b1, 1'b1, 9'h040, 32'h55);
    tick();
    drive(1'b1, 1'b1, 9'h040, 32'h66);
    n_checks++; if (dReadData !== 32'h55) $display("FAIL fwd_rdwr: got %h want 55", dReadData); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 9'h040, 32'h0);
    n_checks++; if (dReadData !== 32'h66) $display("FAIL fwd_young: got %h want 66", dReadData); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL fwd_we: got %b want 0", ram_we); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 9'h044, 32'h0);
    n_checks++; if (dReadData !== 32'hCAFE0044) $display("FAIL fwd_miss: got %h want CAFE0044", dReadData); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (ram_din !== 32'h55) $display("FAIL fwd_order0: got %h want 55", ram_din); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (ram_din !== 32'h66) $display("FAIL fwd_order1: got %h want 66", ram_din); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h040, 32'h0);
    n_checks++; if (dReadData !== 32'h66) $display("FAIL fwd_ramfinal: got %h want 66", dReadData); else n_pass++;
  endtask

  task automatic test_wrap();
    int maxc = 0;
    int bad  = 0;
    logic [8:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      a = 9'($urandom_range(0, 511));
      d = $urandom();
      drive(1'b0, 1'b1, a, d);
      if (int'(count) > maxc) maxc = int'(count);
      tick();
      drive(1'b0, 1'b0, 9'h000, 32'h0);
      if (int'(count) > maxc) maxc = int'(count);
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== a || ram_din !== d)
        $display("FAIL wrap_drain%0d: got we=%b addr=%h din=%h want 1/%h/%h", i, ram_we, ram_addr, ram_din, a, d);
      else n_pass++;
      tick();
    end
    for (int j = 0; j < 512; j++) if (tb_ram[j] !== ref_mem[j]) bad++;
    n_checks++; if (bad != 0) $display("FAIL wrap_ram: got %0d differing words want 0", bad); else n_pass++;
    n_checks++; if (maxc > DEPTH) $display("FAIL wrap_maxcount: got %0d want <= %0d", maxc, DEPTH); else n_pass++;
  endtask

  task automatic test_enq_drain();
    drive(1'b1, 1'b1, 9'h060, 32'h600);
    tick();
    drive(1'b1, 1'b1, 9'h064, 32'h601);
    tick();
    drive(1'b0, 1'b1, 9'h068, 32'h602);
    n_checks++; if (count !== 3'd2) $display("FAIL ed_count_pre: got %0d want 2", count); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL ed_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== 9'h060 || ram_din !== 32'h600) $display("FAIL ed_head: got we=%b addr=%h din=%h want 1/060/600", ram_we, ram_addr, ram_din); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (count !== 3'd2) $display("FAIL ed_count_post: got %0d want 2", count); else n_pass++;
    n_checks++; if (ram_din !== 32'h601) $display("FAIL ed_next: got %h want 601", ram_din); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
    n_checks++; if (ram_addr !== 9'h068 || ram_din !== 32'h602) $display("FAIL ed_tail: got addr=%h din=%h want 068/602", ram_addr, ram_din); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 9'h080 + 9'(4 * i), 32'h800 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 9'h1F0, 32'h0);
    n_checks++; if (count !== 3'd3 || ram_we !== 1'b1) $display("FAIL arst_pre: got count=%0d we=%b want 3/1", count, ram_we); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) $display("FAIL arst_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL arst_flags: got empty=%b full=%b want 1/0", empty, full); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL arst_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 9'h1F0) $display("FAIL arst_addr: got %h want 1F0", ram_addr); else n_pass++;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 9'h000, 32'h0);
      if (ram_we !== 1'b0) pulses++;
      tick();
    end
    n_checks++; if (pulses != 0) $display("FAIL arst_nowrite: got %0d we pulses want 0", pulses); else n_pass++;
    n_checks++; if (tb_ram[9'h080] !== ref_mem[9'h080]) $display("FAIL arst_ram: got %h want %h", tb_ram[9'h080], ref_mem[9'h080]); else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    logic rd, wr;
    logic [8:0] a;
    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(0, 3) == 0);
      wr = 1'($urandom_range(0, 1));
      a  = 9'(32'h0C0 + 4 * $urandom_range(0, 7));
      drive(rd, wr, a, $urandom());
      n_checks++; if (stall !== m_stall()) $display("FAIL rnd_stall@%0d: got %b want %b", i, stall, m_stall()); else n_pass++;
      n_checks++; if (ram_we !== m_we()) $display("FAIL rnd_we@%0d: got %b want %b", i, ram_we, m_we()); else n_pass++;
      n_checks++; if (ram_addr !== m_addr()) $display("FAIL rnd_addr@%0d: got %h want %h", i, ram_addr, m_addr()); else n_pass++;
      if (m_we()) begin
        n_checks++; if (ram_din !== q[0].d) $display("FAIL rnd_din@%0d: got %h want %h", i, ram_din, q[0].d); else n_pass++;
      end
      n_checks++; if (dReadData !== m_dread()) $display("FAIL rnd_rdata@%0d: got %h want %h", i, dReadData, m_dread()); else n_pass++;
      n_checks++; if (count !== CW'(q.size())) $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, q.size()); else n_pass++;
      tick();
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b0, 1'b0, 9'h000, 32'h0);
      tick();
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL rnd_empty: got %b want 1", empty); else n_pass++;
    for (int j = 0; j < 512; j++) if (tb_ram[j] !== ref_mem[j]) bad++;
    n_checks++; if (bad != 0) $display("FAIL rnd_ram: got %0d differing words want 0", bad); else n_pass++;
  endtask

  initial begin
    for (int j = 0; j < 512; j++) begin
      tb_ram[j]  = 32'h0;
      ref_mem[j] = 32'h0;
    end
    test_reset();
    test_single_store();
    test_full_stall();
    test_forwarding();
    test_wrap();
    test_enq_drain();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
